// File: rtl/note_sequencer.sv
// Note sequencer: fetches one note-table entry per beat, opens a hit window,
// and judges player key presses to keep the score and combo counts.
module note_sequencer #(
  parameter int BEAT_CYCLES   = 25_000_000,
  parameter int WINDOW_CYCLES = 10_000_000,
  parameter int SONG_LEN      = 64,
  parameter int ADDR_W        = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        keys,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        note,
  output logic              note_valid,
  output logic              hit,
  output logic              miss,
  output logic [7:0]        score,
  output logic [7:0]        combo,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(BEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SHOW, WAIT, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] index;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        keys_q;
  logic              press;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A held key matches keys_q, so only a change to a non-zero code counts.
  assign press = (keys != 4'd0) && (keys != keys_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = FETCH;
      FETCH:      state_n = (rom_data != 4'd0) ? SHOW : WAIT;
      SHOW:       if (press || cnt == WIN_LAST) state_n = WAIT;
      WAIT: begin
        if (cnt == BEAT_LAST) state_n = (index == LAST_IDX) ? DONE : FETCH;
      end
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    note_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      FETCH:   busy = 1'b1;
      SHOW:    begin busy = 1'b1; note_valid = 1'b1; end
      WAIT:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign rom_addr = index;

  // The beat counter runs through SHOW and WAIT regardless of judgement, so
  // every beat lasts BEAT_CYCLES plus the fetch cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      index  <= '0;
      cnt    <= '0;
      note   <= 4'd0;
      hit    <= 1'b0;
      miss   <= 1'b0;
      score  <= 8'd0;
      combo  <= 8'd0;
      keys_q <= 4'd0;
    end else begin
      keys_q <= keys;
      hit    <= 1'b0;
      miss   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            index <= '0;
            score <= 8'd0;
            combo <= 8'd0;
          end
        end
        FETCH: begin
          note <= rom_data;
          cnt  <= '0;
        end
        SHOW: begin
          cnt <= cnt + CNT_W'(1);
          if (press) begin
            if (keys == note) begin
              hit   <= 1'b1;
              score <= sat_inc(score);
              combo <= sat_inc(combo);
            end else begin
              miss  <= 1'b1;
              combo <= 8'd0;
            end
          end else if (cnt == WIN_LAST) begin
            miss  <= 1'b1;
            combo <= 8'd0;
          end
        end
        WAIT: begin
          if (cnt == BEAT_LAST) begin
            if (index != LAST_IDX) index <= index + ADDR_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
